// File: rtl/turbo_encoder_param.sv
// turbo_encoder_param
//   Parametrised LTE turbo-encoder core: two RSC constituent encoders
//   (g0 = 1+D2+D3 feedback, g1 = 1+D+D3) run PAR_W bits per beat on a joined
//   systematic / interleaved input stream. Each block emits K/PAR_W data beats
//   followed by one tail beat that terminates both trellises.
//   Optional feature macro: ENC_ABORT_EN adds a synchronous 'abort' input.
module turbo_encoder_param #(
   parameter int PAR_W = 8,
   parameter int MAX_K = 6144,
   parameter int LEN_W = 13
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [LEN_W-1:0] blk_len,
   output logic             busy,
   output logic             len_err,
`ifdef ENC_ABORT_EN
   input  logic             abort,
`endif
   input  logic [PAR_W-1:0] sys_din,
   input  logic             sys_valid,
   output logic             sys_ready,
   input  logic [PAR_W-1:0] int_din,
   input  logic             int_valid,
   output logic             int_ready,
   output logic [PAR_W-1:0] xk_out,
   output logic [PAR_W-1:0] zk_out,
   output logic [PAR_W-1:0] zk_prime_out,
   output logic [2:0]       xkp_tail,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             out_tail
);

   localparam int               SH      = $clog2(PAR_W);
   localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(PAR_W);
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_K);

   typedef enum logic [1:0] {IDLE, ENC, TAIL, DRAIN} state_t;

   state_t           state_q;
   logic [2:0]       rsc1_q, rsc2_q;      // {s2, s1, s0}
   logic [LEN_W-1:0] beat_cnt_q, nbeats_q;

   logic [2:0]       rsc1_nxt, rsc2_nxt;
   logic [PAR_W-1:0] enc1_z, enc2_z;
   logic [2:0]       tail1_x, tail1_z, tail2_x, tail2_z;
   logic             space, accept, len_ok, last_beat;

   // One beat of an RSC encoder, bit 0 first; returns {next_state, parity}.
   function automatic logic [PAR_W+2:0] rsc_beat(input logic [PAR_W-1:0] u,
                                                 input logic [2:0]       s_in);
      logic [2:0]       s;
      logic [PAR_W-1:0] z;
      logic             fb;
      s = s_in;
      z = '0;
      for (int i = 0; i < PAR_W; i++) begin
         fb   = u[i] ^ s[1] ^ s[2];
         z[i] = fb ^ s[0] ^ s[2];
         s    = {s[1], s[0], fb};
      end
      return {s, z};
   endfunction

   // Three trellis-termination steps (input chosen so feedback is 0); returns {x, z}.
   function automatic logic [5:0] rsc_tail(input logic [2:0] s_in);
      logic [2:0] s, x, z;
      s = s_in;
      x = '0;
      z = '0;
      for (int t = 0; t < 3; t++) begin
         x[t] = s[1] ^ s[2];
         z[t] = s[0] ^ s[2];
         s    = {s[1], s[0], 1'b0};
      end
      return {x, z};
   endfunction

   assign {rsc1_nxt, enc1_z}   = rsc_beat(sys_din, rsc1_q);
   assign {rsc2_nxt, enc2_z}   = rsc_beat(int_din, rsc2_q);
   assign {tail1_x, tail1_z}   = rsc_tail(rsc1_q);
   assign {tail2_x, tail2_z}   = rsc_tail(rsc2_q);

   // Single output register: it can take a new beat when empty or being drained.
   assign space     = ~out_valid | out_ready;
   // The two inputs are joined; each ready depends on the other's valid.
   assign sys_ready = (state_q == ENC) & int_valid & space;
   assign int_ready = (state_q == ENC) & sys_valid & space;
   assign accept    = (state_q == ENC) & sys_valid & int_valid & space;
   assign last_beat = (beat_cnt_q + 1'b1) == nbeats_q;
   assign len_ok    = (blk_len >= MIN_LEN) && (blk_len <= MAX_LEN) &&
                      (blk_len[SH-1:0] == '0);

   // Block FSM, both RSC states, beat counter and the registered output stage.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         rsc1_q       <= '0;
         rsc2_q       <= '0;
         beat_cnt_q   <= '0;
         nbeats_q     <= '0;
         busy         <= 1'b0;
         len_err      <= 1'b0;
         xk_out       <= '0;
         zk_out       <= '0;
         zk_prime_out <= '0;
         xkp_tail     <= '0;
         out_valid    <= 1'b0;
         out_last     <= 1'b0;
         out_tail     <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout, so later assignments in this block
         // override the defaults below without any ordering hazard.
         len_err <= 1'b0;
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_tail  <= 1'b0;
            xkp_tail  <= '0;
         end
`ifdef ENC_ABORT_EN
         if (abort) begin
            state_q      <= IDLE;
            rsc1_q       <= '0;
            rsc2_q       <= '0;
            beat_cnt_q   <= '0;
            busy         <= 1'b0;
            xk_out       <= '0;
            zk_out       <= '0;
            zk_prime_out <= '0;
            xkp_tail     <= '0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            out_tail     <= 1'b0;
         end else
`endif
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (len_ok) begin
                     nbeats_q   <= blk_len >> SH;
                     beat_cnt_q <= '0;
                     busy       <= 1'b1;
                     state_q    <= ENC;
                  end else begin
                     len_err <= 1'b1;
                  end
               end
            end
            ENC: begin
               if (accept) begin
                  xk_out       <= sys_din;
                  zk_out       <= enc1_z;
                  zk_prime_out <= enc2_z;
                  xkp_tail     <= '0;
                  out_valid    <= 1'b1;
                  out_last     <= last_beat;
                  out_tail     <= 1'b0;
                  rsc1_q       <= rsc1_nxt;
                  rsc2_q       <= rsc2_nxt;
                  beat_cnt_q   <= beat_cnt_q + 1'b1;
                  if (last_beat) state_q <= TAIL;
               end
            end
            TAIL: begin
               if (space) begin
                  xk_out       <= {{(PAR_W-3){1'b0}}, tail1_x};
                  zk_out       <= {{(PAR_W-3){1'b0}}, tail1_z};
                  zk_prime_out <= {{(PAR_W-3){1'b0}}, tail2_z};
                  xkp_tail     <= tail2_x;
                  out_valid    <= 1'b1;
                  out_last     <= 1'b0;
                  out_tail     <= 1'b1;
                  rsc1_q       <= '0;
                  rsc2_q       <= '0;
                  state_q      <= DRAIN;
               end
            end
            DRAIN: begin
               if (out_ready) begin
                  busy       <= 1'b0;
                  beat_cnt_q <= '0;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
